// File: rtl/picomem_dma.sv
// ---------------------------------------------------------------------------
// picomem_dma
//
// Single-channel word-copy DMA engine. Software programs a source address,
// a destination address and a word count through a small PicoMem responder
// port, then sets START. The engine copies the block one word at a time on
// its PicoMem initiator port. Each word is a read followed by a write, and
// there is always one idle cycle between two bus requests.
//
// Parameters:
//   LEN_W   - width of the LEN register (max 2^LEN_W-1 words per transfer)
//   TIMEOUT - cycles to wait for mem_m_ready before aborting (0 = never)
//
// Ports:
//   clk, resetn        - clock, asynchronous active-low reset
//   cfg_valid/ready    - register access request / one-cycle completion pulse
//   cfg_addr           - byte address, only [3:2] decoded
//   cfg_wdata/wstrb    - write data / nonzero strobe = full-word write
//   cfg_rdata          - registered read data, valid with cfg_ready
//   mem_m_valid/ready  - initiator request / completion pulse
//   mem_m_addr         - word-aligned address
//   mem_m_wdata/wstrb  - write data / 4'hF on write, 4'h0 on read
//   mem_m_rdata        - read data, sampled when mem_m_ready=1
//   irq                - high while DONE and IE are both set
//
// Register map (cfg_addr[3:2]):
//   0 SRC, 1 DST (bits [1:0] read as 0), 2 LEN (zero-extended),
//   3 CTRL write {IE, CLR, START} / STAT read {IE, ERR, DONE, BUSY}
// ---------------------------------------------------------------------------
module picomem_dma #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [3:0]  cfg_wstrb,
  output logic [31:0] cfg_rdata,
  output logic        mem_m_valid,
  input  logic        mem_m_ready,
  output logic [31:0] mem_m_addr,
  output logic [31:0] mem_m_wdata,
  output logic [3:0]  mem_m_wstrb,
  input  logic [31:0] mem_m_rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Timeout compare value; the counter reaches TO_LAST on the final
  // permitted wait cycle.
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;

  state_t             state;
  state_t             state_n;
  logic [31:0]        src;
  logic [31:0]        dst;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_dec;
  logic [31:0]        data_q;
  logic [31:0]        tcnt;
  logic [31:0]        rd_mux;
  logic               done;
  logic               err;
  logic               ie;
  logic               gap;
  logic               busy;
  logic               valid_c;
  logic               ready_hit;
  logic               timeout_hit;
  logic               cfg_acc;
  logic               cfg_wr;
  logic               ctrl_wr;
  logic               start_req;
  logic [1:0]         cfg_sel;
  logic               unused_cfg_addr;

  assign cfg_sel         = cfg_addr[3:2];
  assign unused_cfg_addr = ^{cfg_addr[31:4], cfg_addr[1:0]};

  // An access is accepted on the cycle before cfg_ready rises, which also
  // guarantees a single cfg_ready pulse per request.
  assign cfg_acc   = cfg_valid & ~cfg_ready;
  assign cfg_wr    = cfg_acc & (|cfg_wstrb);
  assign ctrl_wr   = cfg_wr & (cfg_sel == 2'd3);

  // BUSY covers only the states with bus traffic; FIN already reports done.
  assign busy      = (state == S_RD) | (state == S_WR);
  assign start_req = ctrl_wr & cfg_wdata[0] & ~busy;

  // The gap flag holds valid low for the one cycle after each handshake.
  assign valid_c     = busy & ~gap;
  assign ready_hit   = valid_c & mem_m_ready;
  assign timeout_hit = TO_EN & valid_c & ~mem_m_ready & (tcnt == TO_LAST);

  assign len_dec = len - LEN_W'(1);
  assign irq     = done & ie;

  // Register read mux; working registers double as live progress values.
  always_comb begin
    rd_mux = 32'd0;
    case (cfg_sel)
      2'd0:    rd_mux = src;
      2'd1:    rd_mux = dst;
      2'd2:    rd_mux[LEN_W-1:0] = len;
      default: rd_mux = {28'd0, ie, err, done, busy};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and bus outputs. Outputs are decoded from state so an
  // asynchronous reset removes a pending request immediately.
  always_comb begin
    state_n     = state;
    mem_m_valid = 1'b0;
    mem_m_addr  = 32'd0;
    mem_m_wdata = 32'd0;
    mem_m_wstrb = 4'h0;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          state_n = (len == '0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        mem_m_valid = valid_c;
        mem_m_addr  = src;
        if (ready_hit) begin
          state_n = S_WR;
        end else if (timeout_hit) begin
          state_n = S_FIN;
        end
      end
      S_WR: begin
        mem_m_valid = valid_c;
        mem_m_addr  = dst;
        mem_m_wdata = data_q;
        mem_m_wstrb = 4'hF;
        if (ready_hit) begin
          state_n = (len_dec == '0) ? S_FIN : S_RD;
        end else if (timeout_hit) begin
          state_n = S_FIN;
        end
      end
      S_FIN: begin
        if (start_req) begin
          state_n = (len == '0) ? S_FIN : S_RD;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath and register file. Later assignments take priority, so
  // START overrides CLR and the transfer-end event sets DONE last.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_ready <= 1'b0;
      cfg_rdata <= 32'd0;
      src       <= 32'd0;
      dst       <= 32'd0;
      len       <= '0;
      data_q    <= 32'd0;
      tcnt      <= 32'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      ie        <= 1'b0;
      gap       <= 1'b0;
    end else begin
      cfg_ready <= cfg_acc;
      if (cfg_acc) begin
        cfg_rdata <= rd_mux;
      end

      if (cfg_wr && !busy) begin
        case (cfg_sel)
          2'd0:    src <= {cfg_wdata[31:2], 2'b00};
          2'd1:    dst <= {cfg_wdata[31:2], 2'b00};
          2'd2:    len <= cfg_wdata[LEN_W-1:0];
          default: ;
        endcase
      end

      if (ctrl_wr) begin
        ie <= cfg_wdata[2];
        if (cfg_wdata[1]) begin
          done <= 1'b0;
          err  <= 1'b0;
        end
      end

      if (start_req) begin
        done <= 1'b0;
        err  <= 1'b0;
      end

      gap <= ready_hit;

      // Counts wait cycles of the current request only.
      if (!valid_c || mem_m_ready) begin
        tcnt <= 32'd0;
      end else begin
        tcnt <= tcnt + 32'd1;
      end

      if (ready_hit && (state == S_RD)) begin
        data_q <= mem_m_rdata;
      end

      if (ready_hit && (state == S_WR)) begin
        src <= src + 32'd4;
        dst <= dst + 32'd4;
        len <= len_dec;
      end

      if (timeout_hit) begin
        err <= 1'b1;
      end

      if (state_n == S_FIN) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/picomem_dma.md
Name: picomem_dma

Overview:
- Single-channel word-copy DMA engine; the first PicoMem bus initiator besides the CPU.
- A PicoMem responder port (cfg_*) lets software program source, destination and length, then start a copy.
- A PicoMem initiator port (mem_m_*) performs the copy: alternating word reads and word writes until the length count reaches zero.
- Placement: cfg_* hangs off a free peripheral mux slot; mem_m_* feeds a 2:1 arbiter in front of the top-level mux (arbiter out of scope).

Parameters:
- LEN_W, 16, width of the LEN register (max words per transfer = 2^LEN_W-1).
- TIMEOUT, 1024, cycles to wait for mem_m_ready before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- cfg_valid  in  1  register access request.
- cfg_ready  out  1  one-cycle completion pulse.
- cfg_addr  in  32  byte address; only [3:2] decoded.
- cfg_wdata  in  32  register write data.
- cfg_wstrb  in  4  nonzero = write (any nonzero strobe writes the full word); 0 = read.
- cfg_rdata  out  32  register read data, valid with cfg_ready.
- mem_m_valid  out  1  bus request.
- mem_m_ready  in  1  bus completion pulse.
- mem_m_addr  out  32  word-aligned address.
- mem_m_wdata  out  32  write data.
- mem_m_wstrb  out  4  4'b1111 on write, 4'b0000 on read.
- mem_m_rdata  in  32  read data, sampled when mem_m_ready=1.
- irq  out  1  level high while DONE=1 and IE=1.

Behaviour:
- Async reset (resetn=0) clears everything immediately, mid-transfer included:
  - all registers and FSM state to 0/IDLE;
  - cfg_ready=0, cfg_rdata=0;
  - mem_m_valid=0, mem_m_addr=0, mem_m_wdata=0, mem_m_wstrb=0;
  - irq=0.
- Register map (cfg_addr[3:2]):
  - 0 SRC: bits[1:0] forced 0.
  - 1 DST: bits[1:0] forced 0.
  - 2 LEN: LEN_W bits, zero-extended on read.
  - 3 CTRL/STAT:
    - write: bit0 START, bit1 CLR (clears DONE and ERR), bit2 IE (stored).
    - read: bit0 BUSY, bit1 DONE, bit2 ERR, bit3 IE.
- cfg handshake:
  - cfg_ready <= cfg_valid & ~cfg_ready, giving 1-cycle latency and a single pulse per access.
  - Writes take effect on the cfg_ready cycle; cfg_rdata is registered alongside cfg_ready.
- While BUSY:
  - writes to SRC, DST and LEN are ignored;
  - reads return live working values (current address, remaining count);
  - START is ignored; CLR and IE are still honoured.
- START while idle: BUSY=1, DONE=0, ERR=0. If CLR is set in the same write, START wins for DONE/ERR.
- FSM states: IDLE, RD, WR, FIN.
  - IDLE -> RD on START with LEN!=0. IDLE -> FIN on START with LEN==0 (no bus traffic).
  - RD: mem_m_valid=1, addr=SRC, wstrb=0.
    - On mem_m_ready: capture mem_m_rdata into the data latch, drop valid for exactly one cycle, go to WR.
  - WR: mem_m_valid=1, addr=DST, wdata=latch, wstrb=4'hF.
    - On mem_m_ready: SRC+=4, DST+=4, LEN-=1.
    - Next state is FIN if the new LEN==0, else RD (again one idle cycle).
  - FIN: BUSY=0, DONE=1, then IDLE one cycle later.
- Bus rules:
  - mem_m_valid, addr, wdata and wstrb stay stable from assertion until the cycle mem_m_ready is seen.
  - Valid deasserts the cycle after ready, so consecutive requests are never back-to-back.
  - Per-word cost: 4 cycles plus wait states.
- Address arithmetic is modulo 2^32: 0xFFFF_FFFC+4 = 0x0000_0000, and the transfer continues.
- Timeout:
  - A counter resets on each new request and counts cycles with valid=1 and ready=0.
  - On reaching TIMEOUT: drop valid, ERR=1, go to FIN (DONE=1).
  - SRC, DST and LEN keep the values of the failing word.
- A late mem_m_ready arriving while idle or in FIN is ignored.
- irq = DONE & IE (registered).

Test Plan:
- Copy 3 words: SRC=0x4000_0000, DST=0x4000_0100, LEN=3, START; memory model has 1 wait state.
  - Required: bus sequence R,W,R,W,R,W with addrs 0x...00/0x...100, 0x...04/0x...104, 0x...08/0x...108; destination data equals source data.
  - Required at end: DONE=1, BUSY=0, ERR=0, LEN reads 0, SRC reads 0x4000_000C.
- LEN=0, START: no mem_m_valid ever asserted; DONE=1 within 2 cycles after cfg_ready; with IE=1, irq=1.
- Model never asserts ready, TIMEOUT=16:
  - After 16 cycles of valid: valid=0, STAT reads 0x6 (DONE|ERR), SRC unchanged.
  - A CLR write then makes STAT read 0x0.
- While BUSY: write LEN=7 and START.
  - Required: both ignored; transfer completes with the original count and exactly one DONE.
- SRC=0xFFFF_FFFC, LEN=2: second read address is 0x0000_0000.
- Assert resetn=0 during a WR wait: mem_m_valid drops the same cycle; after release all registers read 0 and irq=0.
